// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router input-path controller.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;
    localparam logic [ADDR_W-1:0] DROP_ADDR = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } fsm_state_t;

    // DROP_ADDR selects no port, so it yields 0
    function automatic logic port_sel(
        input logic [NUM_PORTS-1:0] bits,
        input logic [ADDR_W-1:0]    a
    );
        logic r;
        r = 1'b0;
        case (a)
            2'd0:    r = bits[0];
            2'd1:    r = bits[1];
            2'd2:    r = bits[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-phase controller for the router input path: header, payload,
// parity and full-stall sequencing plus load/write qualifiers.
module router_fsm
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    fsm_state_t              state;
    fsm_state_t              next;
    logic [ADDR_W-1:0]       addr;
    logic [NUM_PORTS-1:0]    empty_bits;
    logic [NUM_PORTS-1:0]    sr_bits;
    logic                    empty_hdr;
    logic                    empty_addr;
    logic                    soft_rst;

    assign empty_bits = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign sr_bits    = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign empty_hdr  = port_sel(empty_bits, data_in);
    assign empty_addr = port_sel(empty_bits, addr);
    assign soft_rst   = port_sel(sr_bits, addr);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= DECODE_ADDRESS;
            addr  <= DROP_ADDR;
        end else begin
            state <= next;
            if (state == DECODE_ADDRESS && pkt_valid)
                addr <= data_in;
        end
    end

    always_comb begin
        next = DECODE_ADDRESS;
        case (state)
            DECODE_ADDRESS: begin
                if (pkt_valid && data_in != DROP_ADDR)
                    next = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                else
                    next = DECODE_ADDRESS;
            end
            LOAD_FIRST_DATA: next = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       next = FIFO_FULL_STATE;
                else if (!pkt_valid) next = LOAD_PARITY;
                else                 next = LOAD_DATA;
            end
            FIFO_FULL_STATE:
                next = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
                if (parity_done)        next = DECODE_ADDRESS;
                else if (low_pkt_valid) next = LOAD_PARITY;
                else                    next = LOAD_DATA;
            end
            LOAD_PARITY: next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:
                next = empty_addr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            default: next = DECODE_ADDRESS;
        endcase
        // a timed-out port aborts whatever packet is in flight
        if (soft_rst)
            next = DECODE_ADDRESS;
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b0;
        case (state)
            DECODE_ADDRESS: detect_add = 1'b1;
            LOAD_FIRST_DATA: begin
                lfd_state = 1'b1;
                busy      = 1'b1;
            end
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            FIFO_FULL_STATE: begin
                full_state = 1'b1;
                busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b1;
            end
            WAIT_TILL_EMPTY: busy = 1'b1;
            CHECK_PARITY_ERROR: begin
                rst_int_reg = 1'b1;
                busy        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
